// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: issues word fetches over a req/ack port and
// queues {pc, inst} pairs for IF/ID. Redirects flush the queue and any in-flight data.
//
// state | meaning
// ISSUE | no request outstanding
// WAIT  | request outstanding, returned data will be queued
// DRAIN | request outstanding, returned data will be discarded
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  input  logic                     deq_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_mem_q [DEPTH];
  logic [31:0]     pc_mem_d [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];

  logic            ack;
  logic            push;
  logic            pop;
  logic            space;
  logic [OW-1:0]   occ_next;
  logic [31:0]     redir_pc;
  logic [31:0]     next_addr;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign count     = count_q;

  // An ack only means something while a request is actually on the port.
  assign ack       = mem_req_q && mem_ack;
  assign pop       = out_valid && deq_ready;
  assign push      = (state_q == ST_WAIT) && ack && !redirect;
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign next_addr = mem_addr_q + 32'd4;

  // A new request needs a free slot after this cycle's push/pop settle.
  always_comb begin
    occ_next = {1'b0, count_q} + OW'(push) - OW'(pop);
    space    = (int'(occ_next) < DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      ST_ISSUE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end else if (!halt && space) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
          if (ack) begin
            mem_req_d = 1'b0;
            state_d   = ST_ISSUE;
          end else begin
            state_d   = ST_DRAIN;
          end
        end else if (ack) begin
          fetch_pc_d = next_addr;
          if (!halt && space) begin
            mem_addr_d = next_addr;
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end
        if (ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_ISSUE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = mem_addr_q;
        inst_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = occ_next[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= 32'h0000_0000;
        inst_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: streaming, back-pressure, slow ack,
// redirect drain, halt and async reset, with hand-computed expectations.
module tb_fetch_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  logic        auto_ack;
  logic        ack_man;
  logic [31:0] rdata_man;

  int passed;
  int total;

  fetch_prefetch_buffer #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0033)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .deq_ready(deq_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-ack memory returns addr ^ A5A50000; manual mode drives the port directly.
  always_comb begin
    mem_ack   = ack_man;
    mem_rdata = rdata_man;
    if (auto_ack) begin
      mem_ack   = mem_req;
      mem_rdata = mem_addr ^ 32'hA5A5_0000;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_req", {31'b0, mem_req}, 32'h0);
    chk("rst_async_cnt", {29'b0, count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    auto_ack    = 1'b1;
    ack_man     = 1'b0;
    rdata_man   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    deq_ready   = 1'b1;

    // Reset values
    #2;
    chk("reset_req",   {31'b0, mem_req}, 32'h0);
    chk("reset_addr",  mem_addr, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_pc",    out_pc, 32'h0);
    chk("reset_inst",  out_inst, 32'h0000_0033);
    chk("reset_count", {29'b0, count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with single-cycle ack
    chk("s1_rel_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("s1_req0",   {31'b0, mem_req}, 32'h1);
    chk("s1_addr0",  mem_addr, 32'h0);
    chk("s1_val0",   {31'b0, out_valid}, 32'h0);
    chk("s1_nop0",   out_inst, 32'h0000_0033);
    tick();
    chk("s1_val1",   {31'b0, out_valid}, 32'h1);
    chk("s1_pc1",    out_pc, 32'h0);
    chk("s1_inst1",  out_inst, 32'hA5A5_0000);
    chk("s1_addr1",  mem_addr, 32'h4);
    chk("s1_cnt1",   {29'b0, count}, 32'h1);
    tick();
    chk("s1_pc2",    out_pc, 32'h4);
    chk("s1_inst2",  out_inst, 32'hA5A5_0004);
    chk("s1_addr2",  mem_addr, 32'h8);
    tick();
    chk("s1_pc3",    out_pc, 32'h8);
    chk("s1_addr3",  mem_addr, 32'hC);

    // Back-pressure from reset: exactly four requests, then stop
    @(negedge clk);
    deq_ready = 1'b0;
    do_reset();
    tick();
    chk("s2_addr0", mem_addr, 32'h0);
    tick();
    chk("s2_addr4", mem_addr, 32'h4);
    tick();
    chk("s2_addr8", mem_addr, 32'h8);
    tick();
    chk("s2_addr12", mem_addr, 32'hC);
    chk("s2_cnt3",   {29'b0, count}, 32'h3);
    tick();
    chk("s2_req_off", {31'b0, mem_req}, 32'h0);
    chk("s2_full",    {29'b0, count}, 32'h4);
    chk("s2_head",    out_pc, 32'h0);
    tick();
    chk("s2_hold_req", {31'b0, mem_req}, 32'h0);
    chk("s2_hold_cnt", {29'b0, count}, 32'h4);
    deq_ready = 1'b1;
    tick();
    chk("s2_pc4",     out_pc, 32'h4);
    chk("s2_resume",  {31'b0, mem_req}, 32'h1);
    chk("s2_addr16",  mem_addr, 32'h10);
    chk("s2_cnt_pop", {29'b0, count}, 32'h3);
    tick();
    chk("s2_pc8",     out_pc, 32'h8);
    chk("s2_cnt_pp",  {29'b0, count}, 32'h3);
    tick();
    chk("s2_pc12",    out_pc, 32'hC);
    tick();
    chk("s2_pc16",    out_pc, 32'h10);
    chk("s2_inst16",  out_inst, 32'hA5A5_0010);

    // Slow memory: request held stable until ack
    auto_ack = 1'b0;
    do_reset();
    tick();
    chk("s3_req",    {31'b0, mem_req}, 32'h1);
    chk("s3_addr",   mem_addr, 32'h0);
    tick();
    chk("s3_hold1",  mem_addr, 32'h0);
    chk("s3_cnt1",   {29'b0, count}, 32'h0);
    tick();
    chk("s3_hold2",  mem_addr, 32'h0);
    chk("s3_hreq2",  {31'b0, mem_req}, 32'h1);
    ack_man   = 1'b1;
    rdata_man = 32'h1234_5678;
    tick();
    ack_man   = 1'b0;
    chk("s3_valid",  {31'b0, out_valid}, 32'h1);
    chk("s3_inst",   out_inst, 32'h1234_5678);
    chk("s3_next",   mem_addr, 32'h4);
    tick();
    chk("s3_empty",  {31'b0, out_valid}, 32'h0);
    chk("s3_nop",    out_inst, 32'h0000_0033);
    chk("s3_pc0",    out_pc, 32'h0);
    chk("s3_wait4",  mem_addr, 32'h4);

    // Redirect while the request to 8 is outstanding
    deq_ready = 1'b0;
    ack_man   = 1'b1;
    rdata_man = 32'h0BAD_0004;
    tick();
    ack_man   = 1'b0;
    chk("s4_pc4",    out_pc, 32'h4);
    chk("s4_addr8",  mem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0041;
    tick();
    redirect    = 1'b0;
    chk("s4_flush_v", {31'b0, out_valid}, 32'h0);
    chk("s4_flush_i", out_inst, 32'h0000_0033);
    chk("s4_drain_req", {31'b0, mem_req}, 32'h1);
    chk("s4_drain_adr", mem_addr, 32'h8);
    tick();
    chk("s4_drain_hold", mem_addr, 32'h8);
    ack_man   = 1'b1;
    rdata_man = 32'hDEAD_BEEF;
    tick();
    ack_man   = 1'b0;
    chk("s4_discard", {29'b0, count}, 32'h0);
    chk("s4_req_off", {31'b0, mem_req}, 32'h0);
    tick();
    chk("s4_new_req", {31'b0, mem_req}, 32'h1);
    chk("s4_new_adr", mem_addr, 32'h40);

    // Halt raised while waiting on address 20
    deq_ready = 1'b1;
    auto_ack  = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    chk("s5_addr20", mem_addr, 32'h14);
    auto_ack = 1'b0;
    halt     = 1'b1;
    tick();
    chk("s5_hold_req", {31'b0, mem_req}, 32'h1);
    chk("s5_hold_adr", mem_addr, 32'h14);
    ack_man   = 1'b1;
    rdata_man = 32'h0000_5014;
    tick();
    ack_man   = 1'b0;
    chk("s5_pushed",   out_pc, 32'h14);
    chk("s5_pinst",    out_inst, 32'h0000_5014);
    chk("s5_req_off",  {31'b0, mem_req}, 32'h0);
    tick();
    chk("s5_drained",  {31'b0, out_valid}, 32'h0);
    chk("s5_no_req",   {31'b0, mem_req}, 32'h0);
    tick();
    chk("s5_no_req2",  {31'b0, mem_req}, 32'h0);
    halt = 1'b0;
    tick();
    chk("s5_resume",   {31'b0, mem_req}, 32'h1);
    chk("s5_addr24",   mem_addr, 32'h18);

    // Asynchronous reset mid-transaction; ack during reset is ignored
    rst = 1'b1;
    #1;
    chk("s6_req",   {31'b0, mem_req}, 32'h0);
    chk("s6_addr",  mem_addr, 32'h0);
    chk("s6_valid", {31'b0, out_valid}, 32'h0);
    chk("s6_inst",  out_inst, 32'h0000_0033);
    ack_man   = 1'b1;
    rdata_man = 32'hFFFF_FFFF;
    tick();
    chk("s6_ack_ign", {29'b0, count}, 32'h0);
    ack_man  = 1'b0;
    rst      = 1'b0;
    auto_ack = 1'b1;
    tick();
    chk("s6_first_req", {31'b0, mem_req}, 32'h1);
    chk("s6_first_adr", mem_addr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
